// File: rtl/gb_regfile_wb.sv
// gb_regfile_wb: writeback stage and register bank behind the CPU ALU.
//
// An ALU result is captured into a one-entry pending stage, then committed to
// A, F, B, C, D, E, H, L and SP on the following clock. Read ports are
// combinational and feed the ALU X/Y/fIn operands.
//
// Optional feature: define REGFILE_BYPASS_EN so that reads return the state the
// pending entry will produce. Without it, reads show committed state only and
// rdHazard flags reads that overlap the pending entry.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wbValid              writeback request, accepted every edge it is high
//   wbDataEn             write wbData to the selected target
//   wbIs16               1 = pair write (wbPair), 0 = byte write (wbReg8)
//   wbReg8 / wbPair      byte target B,C,D,E,H,L,-,A / pair target BC,DE,HL,SP,AF
//   wbData, wbFlags      result data and {Z,N,H,C}
//   wbFlagMask           per-flag write enable
//   hlStep               00 none, 01 HL+1, 10 HL-1, 11 none
//   rdSelX/rdSelY/rdPair read selects
//   rdX/rdY/rdPairData   read data
//   flags                {Z,N,H,C}
//   pendValid, rdHazard  pending stage occupied / read overlaps pending entry
module gb_regfile_wb #(
    parameter int unsigned SKIP_BOOT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbValid,
    input  logic        wbDataEn,
    input  logic        wbIs16,
    input  logic [2:0]  wbReg8,
    input  logic [2:0]  wbPair,
    input  logic [15:0] wbData,
    input  logic [3:0]  wbFlags,
    input  logic [3:0]  wbFlagMask,
    input  logic [1:0]  hlStep,
    input  logic [2:0]  rdSelX,
    input  logic [2:0]  rdSelY,
    input  logic [2:0]  rdPair,
    output logic [7:0]  rdX,
    output logic [7:0]  rdY,
    output logic [15:0] rdPairData,
    output logic [3:0]  flags,
    output logic        pendValid,
    output logic        rdHazard
);

    // F holds only the flag nibble; its low nibble always reads as zero.
    typedef struct packed {
        logic [7:0]  a;
        logic [3:0]  f;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [7:0]  d;
        logic [7:0]  e;
        logic [7:0]  h;
        logic [7:0]  l;
        logic [15:0] sp;
    } regs_t;

    typedef struct packed {
        logic        data_en;
        logic        is16;
        logic [2:0]  reg8;
        logic [2:0]  pair;
        logic [15:0] data;
        logic [3:0]  flg;
        logic [3:0]  mask;
        logic [1:0]  step;
    } pend_t;

    localparam regs_t RegsRst = (SKIP_BOOT != 0) ?
        '{a: 8'h01, f: 4'hB, b: 8'h00, c: 8'h13, d: 8'h00, e: 8'hD8,
          h: 8'h01, l: 8'h4D, sp: 16'hFFFE} :
        '{a: 8'h00, f: 4'h0, b: 8'h00, c: 8'h00, d: 8'h00, e: 8'h00,
          h: 8'h00, l: 8'h00, sp: 16'h0000};

    regs_t regs_q, regs_nxt, regs_rd;
    pend_t pend_q;
    logic  pend_valid_q;
    logic  writes_hl;

    // State after the pending entry commits (equals regs_q when stage empty).
    always_comb begin
        regs_nxt  = regs_q;
        writes_hl = 1'b0;
        if (pend_valid_q) begin
            if (pend_q.data_en) begin
                if (!pend_q.is16) begin
                    case (pend_q.reg8)
                        3'd0:    regs_nxt.b = pend_q.data[7:0];
                        3'd1:    regs_nxt.c = pend_q.data[7:0];
                        3'd2:    regs_nxt.d = pend_q.data[7:0];
                        3'd3:    regs_nxt.e = pend_q.data[7:0];
                        3'd4:    regs_nxt.h = pend_q.data[7:0];
                        3'd5:    regs_nxt.l = pend_q.data[7:0];
                        3'd7:    regs_nxt.a = pend_q.data[7:0];
                        default: ;
                    endcase
                    writes_hl = (pend_q.reg8 == 3'd4) || (pend_q.reg8 == 3'd5);
                end else begin
                    case (pend_q.pair)
                        3'd0:    {regs_nxt.b, regs_nxt.c} = pend_q.data;
                        3'd1:    {regs_nxt.d, regs_nxt.e} = pend_q.data;
                        3'd2:    {regs_nxt.h, regs_nxt.l} = pend_q.data;
                        3'd3:    regs_nxt.sp = pend_q.data;
                        3'd4:    {regs_nxt.a, regs_nxt.f} = pend_q.data[15:4];
                        default: ;
                    endcase
                    writes_hl = (pend_q.pair == 3'd2);
                end
            end
            // Flag merge after the data write so masked bits win over an AF write.
            regs_nxt.f = (regs_nxt.f & ~pend_q.mask) | (pend_q.flg & pend_q.mask);
            if (!writes_hl) begin
                case (pend_q.step)
                    2'b01:   {regs_nxt.h, regs_nxt.l} = {regs_q.h, regs_q.l} + 16'd1;
                    2'b10:   {regs_nxt.h, regs_nxt.l} = {regs_q.h, regs_q.l} - 16'd1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q       <= RegsRst;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            regs_q       <= regs_nxt;
            pend_valid_q <= wbValid;
            if (wbValid) begin
                pend_q <= '{data_en: wbDataEn, is16: wbIs16, reg8: wbReg8, pair: wbPair,
                            data: wbData, flg: wbFlags, mask: wbFlagMask, step: hlStep};
            end
        end
    end

    function automatic logic [7:0] rd_byte(input regs_t r, input logic [2:0] sel);
        case (sel)
            3'd0:    rd_byte = r.b;
            3'd1:    rd_byte = r.c;
            3'd2:    rd_byte = r.d;
            3'd3:    rd_byte = r.e;
            3'd4:    rd_byte = r.h;
            3'd5:    rd_byte = r.l;
            3'd7:    rd_byte = r.a;
            default: rd_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] rd_word(input regs_t r, input logic [2:0] sel);
        case (sel)
            3'd0:    rd_word = {r.b, r.c};
            3'd1:    rd_word = {r.d, r.e};
            3'd2:    rd_word = {r.h, r.l};
            3'd3:    rd_word = r.sp;
            3'd4:    rd_word = {r.a, r.f, 4'h0};
            default: rd_word = 16'h0000;
        endcase
    endfunction

`ifdef REGFILE_BYPASS_EN
    assign regs_rd  = regs_nxt;
    assign rdHazard = 1'b0;
`else
    // Register footprint bits: {SP, F, A, L, H, E, D, C, B}.
    localparam logic [8:0] MskB  = 9'h001;
    localparam logic [8:0] MskC  = 9'h002;
    localparam logic [8:0] MskD  = 9'h004;
    localparam logic [8:0] MskE  = 9'h008;
    localparam logic [8:0] MskH  = 9'h010;
    localparam logic [8:0] MskL  = 9'h020;
    localparam logic [8:0] MskA  = 9'h040;
    localparam logic [8:0] MskF  = 9'h080;
    localparam logic [8:0] MskSp = 9'h100;

    function automatic logic [8:0] byte_mask(input logic [2:0] sel);
        case (sel)
            3'd0:    byte_mask = MskB;
            3'd1:    byte_mask = MskC;
            3'd2:    byte_mask = MskD;
            3'd3:    byte_mask = MskE;
            3'd4:    byte_mask = MskH;
            3'd5:    byte_mask = MskL;
            3'd7:    byte_mask = MskA;
            default: byte_mask = 9'h000;
        endcase
    endfunction

    function automatic logic [8:0] pair_mask(input logic [2:0] sel);
        case (sel)
            3'd0:    pair_mask = MskB | MskC;
            3'd1:    pair_mask = MskD | MskE;
            3'd2:    pair_mask = MskH | MskL;
            3'd3:    pair_mask = MskSp;
            3'd4:    pair_mask = MskA | MskF;
            default: pair_mask = 9'h000;
        endcase
    endfunction

    logic [8:0] pend_touch, rd_touch;

    always_comb begin
        pend_touch = 9'h000;
        if (pend_q.data_en) begin
            pend_touch = pend_q.is16 ? pair_mask(pend_q.pair) : byte_mask(pend_q.reg8);
        end
        if (pend_q.step != 2'b00) begin
            pend_touch = pend_touch | MskH | MskL;
        end
        // F is only reachable through rdPair=AF; the flags port is not checked.
        if (pend_q.mask != 4'h0) begin
            pend_touch = pend_touch | MskF;
        end
        rd_touch = byte_mask(rdSelX) | byte_mask(rdSelY) | pair_mask(rdPair);
    end

    assign regs_rd  = regs_q;
    assign rdHazard = pend_valid_q && ((rd_touch & pend_touch) != 9'h000);
`endif

    assign rdX        = rd_byte(regs_rd, rdSelX);
    assign rdY        = rd_byte(regs_rd, rdSelY);
    assign rdPairData = rd_word(regs_rd, rdPair);
    assign flags      = regs_rd.f;
    assign pendValid  = pend_valid_q;

endmodule

// File: tb/tb_gb_regfile_wb.sv
module tb_gb_regfile_wb;

    logic        clk;
    logic        rst_n;
    logic        wbValid;
    logic        wbDataEn;
    logic        wbIs16;
    logic [2:0]  wbReg8;
    logic [2:0]  wbPair;
    logic [15:0] wbData;
    logic [3:0]  wbFlags;
    logic [3:0]  wbFlagMask;
    logic [1:0]  hlStep;
    logic [2:0]  rdSelX;
    logic [2:0]  rdSelY;
    logic [2:0]  rdPair;

    logic [7:0]  rdX, rdY, rdX0, rdY0;
    logic [15:0] rdPairData, rdPairData0;
    logic [3:0]  flags, flags0;
    logic        pendValid, pendValid0, rdHazard, rdHazard0;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: kind 0 = rdX, 1 = rdPairData, 2 = flags.
    typedef struct {
        string       tag;
        int          kind;
        logic [2:0]  sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    gb_regfile_wb #(.SKIP_BOOT(1)) dut (
        .clk(clk), .rst_n(rst_n), .wbValid(wbValid), .wbDataEn(wbDataEn),
        .wbIs16(wbIs16), .wbReg8(wbReg8), .wbPair(wbPair), .wbData(wbData),
        .wbFlags(wbFlags), .wbFlagMask(wbFlagMask), .hlStep(hlStep),
        .rdSelX(rdSelX), .rdSelY(rdSelY), .rdPair(rdPair),
        .rdX(rdX), .rdY(rdY), .rdPairData(rdPairData), .flags(flags),
        .pendValid(pendValid), .rdHazard(rdHazard)
    );

    gb_regfile_wb #(.SKIP_BOOT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wbValid(wbValid), .wbDataEn(wbDataEn),
        .wbIs16(wbIs16), .wbReg8(wbReg8), .wbPair(wbPair), .wbData(wbData),
        .wbFlags(wbFlags), .wbFlagMask(wbFlagMask), .hlStep(hlStep),
        .rdSelX(rdSelX), .rdSelY(rdSelY), .rdPair(rdPair),
        .rdX(rdX0), .rdY(rdY0), .rdPairData(rdPairData0), .flags(flags0),
        .pendValid(pendValid0), .rdHazard(rdHazard0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void push(input string tag, input int kind, input logic [2:0] sel,
                                 input logic [15:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic is16, input logic [2:0] code, input logic [15:0] data,
                          input logic en, input logic [3:0] fl, input logic [3:0] mk,
                          input logic [1:0] step);
        wbValid    = 1'b1;
        wbIs16     = is16;
        wbReg8     = code;
        wbPair     = code;
        wbData     = data;
        wbDataEn   = en;
        wbFlags    = fl;
        wbFlagMask = mk;
        hlStep     = step;
    endtask

    task automatic drive(input logic is16, input logic [2:0] code, input logic [15:0] data,
                         input logic en, input logic [3:0] fl, input logic [3:0] mk,
                         input logic [1:0] step);
        set_wb(is16, code, data, en, fl, mk, step);
        tick();
        wbValid = 1'b0;
    endtask

    // Compare every queued expectation against the committed read ports.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0: begin rdSelX = e.sel; #1; check(e.tag, {8'h00, rdX}, e.exp); end
                1: begin rdPair = e.sel; #1; check(e.tag, rdPairData, e.exp); end
                default: begin #1; check(e.tag, {12'h000, flags}, e.exp); end
            endcase
        end
        rdSelX = 3'd0;
        rdPair = 3'd0;
    endtask

    initial begin
        rst_n = 1'b1;
        wbValid = 1'b0; wbDataEn = 1'b0; wbIs16 = 1'b0; wbReg8 = 3'd0; wbPair = 3'd0;
        wbData = 16'h0000; wbFlags = 4'h0; wbFlagMask = 4'h0; hlStep = 2'b00;
        rdSelX = 3'd0; rdSelY = 3'd0; rdPair = 3'd4;
        #1 rst_n = 1'b0;
        #1;
        check("rst_af_boot", rdPairData, 16'h01B0);
        check("rst_af_zero", rdPairData0, 16'h0000);
        check("rst_flags_boot", {12'h0, flags}, 16'h000B);
        check("rst_pend", {14'h0, pendValid, pendValid0}, 16'h0000);
        check("rst_hazard", {14'h0, rdHazard, rdHazard0}, 16'h0000);
        rdPair = 3'd3;
        #1;
        check("rst_sp_boot", rdPairData, 16'hFFFE);
        check("rst_sp_zero", rdPairData0, 16'h0000);
        rdSelX = 3'd1;
        #1;
        check("rst_c_boot", {8'h0, rdX}, 16'h0013);
        check("rst_c_zero", {8'h0, rdX0}, 16'h0000);
        rdSelX = 3'd0;
        rdPair = 3'd0;
        #1 rst_n = 1'b1;
        tick();

        // Byte write A=3C with full flag update.
        drive(1'b0, 3'd7, 16'h003C, 1'b1, 4'hA, 4'hF, 2'b00);
        push("a_byte", 0, 3'd7, 16'h003C);
        push("a_flags", 2, 3'd0, 16'h000A);
        check("a_pend", {15'h0, pendValid}, 16'h0001);
        check("a_nohaz_b", {15'h0, rdHazard}, 16'h0000);
        rdSelX = 3'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("a_haz", {15'h0, rdHazard}, 16'h0000);
        check("a_bypass", {8'h0, rdX}, 16'h003C);
`else
        check("a_haz", {15'h0, rdHazard}, 16'h0001);
        check("a_old", {8'h0, rdX}, 16'h0001);
`endif
        rdSelX = 3'd0;
        tick();
        check("a_pend_clr", {15'h0, pendValid}, 16'h0000);
        drain();

        // AF write: F low nibble forced to zero, flags from data.
        drive(1'b1, 3'd4, 16'h12FF, 1'b1, 4'h0, 4'h0, 2'b00);
        tick();
        push("af_pair", 1, 3'd4, 16'h12F0);
        push("af_flags", 2, 3'd0, 16'h000F);
        push("af_a", 0, 3'd7, 16'h0012);
        drain();

        // HL wrap up and down; step discarded with a same-entry HL write.
        drive(1'b1, 3'd2, 16'hFFFF, 1'b1, 4'h0, 4'h0, 2'b00);
        tick();
        push("hl_ffff", 1, 3'd2, 16'hFFFF);
        drain();
        drive(1'b1, 3'd2, 16'h0000, 1'b0, 4'h0, 4'h0, 2'b01);
        rdPair = 3'd2;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hl_inc_haz", {15'h0, rdHazard}, 16'h0000);
        check("hl_inc_bypass", rdPairData, 16'h0000);
`else
        check("hl_inc_haz", {15'h0, rdHazard}, 16'h0001);
`endif
        rdPair = 3'd0;
        tick();
        push("hl_inc_wrap", 1, 3'd2, 16'h0000);
        drain();
        drive(1'b1, 3'd2, 16'h0000, 1'b0, 4'h0, 4'h0, 2'b10);
        tick();
        push("hl_dec_wrap", 1, 3'd2, 16'hFFFF);
        drain();
        drive(1'b1, 3'd2, 16'h1234, 1'b1, 4'h0, 4'h0, 2'b10);
        tick();
        push("hl_step_drop", 1, 3'd2, 16'h1234);
        drain();

        // Back-to-back B writes commit in order.
        set_wb(1'b0, 3'd0, 16'h0011, 1'b1, 4'h0, 4'h0, 2'b00);
        tick();
`ifdef REGFILE_BYPASS_EN
        check("b2b_first", {8'h0, rdX}, 16'h0011);
`endif
        set_wb(1'b0, 3'd0, 16'h0022, 1'b1, 4'h0, 4'h0, 2'b00);
        tick();
        wbValid = 1'b0;
        check("b2b_pend", {15'h0, pendValid}, 16'h0001);
`ifdef REGFILE_BYPASS_EN
        check("b2b_second", {8'h0, rdX}, 16'h0022);
`else
        check("b2b_order", {8'h0, rdX}, 16'h0011);
        check("b2b_haz", {15'h0, rdHazard}, 16'h0001);
`endif
        tick();
        push("b2b_final", 0, 3'd0, 16'h0022);
        drain();

        // Byte target 6: data dropped, partial flag mask still applies.
        drive(1'b0, 3'd6, 16'h00FF, 1'b1, 4'h0, 4'h5, 2'b00);
        tick();
        push("none_flags", 2, 3'd0, 16'h000A);
        push("none_a", 0, 3'd7, 16'h0012);
        push("none_rd6", 0, 3'd6, 16'h0000);
        push("none_hl", 1, 3'd2, 16'h1234);
        drain();

        // AF data write with a mask: masked flag bits override data.
        drive(1'b1, 3'd4, 16'h3400, 1'b1, 4'h8, 4'h8, 2'b00);
        tick();
        push("afm_pair", 1, 3'd4, 16'h3480);
        push("afm_flags", 2, 3'd0, 16'h0008);
        drain();

        // SP write, then a write to pair code 5 is dropped.
        drive(1'b1, 3'd3, 16'hBEEF, 1'b1, 4'h0, 4'h0, 2'b00);
        drive(1'b1, 3'd5, 16'h5555, 1'b1, 4'h0, 4'h0, 2'b00);
        tick();
        push("sp_pair", 1, 3'd3, 16'hBEEF);
        push("pair5_rd", 1, 3'd5, 16'h0000);
        push("pair5_sp", 1, 3'd3, 16'hBEEF);
        drain();

        // Reset while C=55 is pending: entry is dropped.
        drive(1'b0, 3'd1, 16'h0055, 1'b1, 4'h0, 4'h0, 2'b00);
        check("rstmid_pend_pre", {15'h0, pendValid}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check("rstmid_pend", {15'h0, pendValid}, 16'h0000);
        rdSelX = 3'd1;
        #1;
        check("rstmid_c", {8'h0, rdX}, 16'h0013);
        rst_n = 1'b1;
        rdSelX = 3'd0;
        tick();
        push("rstmid_c_after", 0, 3'd1, 16'h0013);
        push("rstmid_sp_after", 1, 3'd3, 16'hFFFE);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
